// File: rtl/ex_muldiv_pkg.sv
// Shared M-extension decode constants and mul/div FSM encodings.
// Pure definitions: no latency, no flow control.
package ex_muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_ITERS = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Conditional two's-complement negate, used both for magnitudes and the final sign fix.
    function automatic logic [MD_XLEN-1:0] cneg32(input logic [MD_XLEN-1:0] v, input logic en);
        return en ? (~v + {{(MD_XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> mul/div unit signal bundle; master is the EX stage, slave is the unit.
// No storage; stall is the only backpressure and it flows slave -> master.
interface ex_muldiv_if #(parameter int XLEN = 32);
    logic            valid_ex;
    logic [2:0]      funct3_ex;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic [XLEN-1:0] result;
    logic            result_valid;

    modport master (
        output valid_ex, funct3_ex, op_a, op_b, flush,
        input  stall, result, result_valid
    );

    modport slave (
        input  valid_ex, funct3_ex, op_a, op_b, flush,
        output stall, result, result_valid
    );
endinterface

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration on {acc, opr}: shift-add multiply or restoring divide.
// Purely combinational, no backpressure.
module ex_muldiv_step (
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] opr,
    input  logic [31:0] mop,
    output logic [31:0] acc_nxt,
    output logic [31:0] opr_nxt
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    always_comb begin
        sum     = {1'b0, acc};
        shifted = {acc, opr[31]};
        diff    = shifted[31:0] - mop;
        fits    = (shifted >= {1'b0, mop});
        acc_nxt = acc;
        opr_nxt = opr;

        if (is_div) begin
            // Partial remainder stays below the divisor, so a 32-bit difference is exact when it fits.
            if (fits) begin
                acc_nxt = diff;
                opr_nxt = {opr[30:0], 1'b1};
            end else begin
                acc_nxt = shifted[31:0];
                opr_nxt = {opr[30:0], 1'b0};
            end
        end else begin
            if (opr[0]) begin
                sum = {1'b0, acc} + {1'b0, mop};
            end
            acc_nxt = sum[32:1];
            opr_nxt = {sum[0], opr[31:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide in EX: latches operands, 32 one-bit iterations, sign fix in DONE (33 cycles, 1 for shortcuts).
// Holds stall high while working; result_valid is a single-cycle strobe from DONE.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);

    localparam logic [5:0] CNT_LAST = 6'(MD_ITERS - 1);

    md_state_e       state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [XLEN-1:0] mop_q, mop_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opr_q, opr_d;

    logic            signed_a, signed_b, sa, sb, is_div_in, div0, ovf;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] step_acc, step_opr;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] fixed;

    always_comb begin
        signed_a  = (bus.funct3_ex != F3_MULHU) && (bus.funct3_ex != F3_DIVU) &&
                    (bus.funct3_ex != F3_REMU);
        signed_b  = signed_a && (bus.funct3_ex != F3_MULHSU);
        sa        = signed_a && bus.op_a[XLEN-1];
        sb        = signed_b && bus.op_b[XLEN-1];
        mag_a     = cneg32(bus.op_a, sa);
        mag_b     = cneg32(bus.op_b, sb);
        is_div_in = bus.funct3_ex[2];
        div0      = is_div_in && (bus.op_b == '0);
        ovf       = is_div_in && !bus.funct3_ex[0] &&
                    (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    end

    ex_muldiv_step u_step (
        .is_div  (f3_q[2]),
        .acc     (acc_q),
        .opr     (opr_q),
        .mop     (mop_q),
        .acc_nxt (step_acc),
        .opr_nxt (step_opr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        mop_d   = mop_q;
        acc_d   = acc_q;
        opr_d   = opr_q;

        case (state_q)
            MD_IDLE: begin
                if (bus.valid_ex && !bus.flush) begin
                    f3_d  = bus.funct3_ex;
                    cnt_d = '0;
                    mop_d = mag_b;
                    // Shortcuts preload final quotient/remainder with no sign fix left to apply.
                    if (div0) begin
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        acc_d   = bus.op_a;
                        opr_d   = '1;
                        state_d = MD_DONE;
                    end else if (ovf) begin
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        acc_d   = '0;
                        opr_d   = {1'b1, {(XLEN-1){1'b0}}};
                        state_d = MD_DONE;
                    end else begin
                        neg_a_d = sa;
                        neg_b_d = sb;
                        acc_d   = '0;
                        opr_d   = mag_a;
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    acc_d = step_acc;
                    opr_d = step_opr;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mop_q   <= '0;
            acc_q   <= '0;
            opr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            mop_q   <= mop_d;
            acc_q   <= acc_d;
            opr_q   <= opr_d;
        end
    end

    always_comb begin
        prod = {acc_q, opr_q};
        if (neg_a_q ^ neg_b_q) begin
            prod = ~prod + {{(2*XLEN-1){1'b0}}, 1'b1};
        end
        fixed = '0;
        case (f3_q)
            F3_MUL:                       fixed = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fixed = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fixed = cneg32(opr_q, neg_a_q ^ neg_b_q);
            default:                      fixed = cneg32(acc_q, neg_a_q);
        endcase
    end

    // Stall is combinational so the hazard unit sees it in the start cycle; reset forces it low.
    assign bus.stall        = rst && !bus.flush &&
                              (((state_q == MD_IDLE) && bus.valid_ex) || (state_q == MD_BUSY));
    assign bus.result_valid = (state_q == MD_DONE);
    assign bus.result       = (state_q == MD_DONE) ? fixed : '0;

endmodule
